logic_lab_sequencer: RTL and testbench

Controller that owns the 3-bit input bus of the registered gate bank (AND/NAND/OR3/NOR/sum/MUX/XOR outputs) and decides what drives it. In manual mode it passes debounced push-button values to the bank. In auto mode it runs a self-test: it steps all eight input vectors, checks each captured bank output against an internal golden model, and reports pass/fail with the first failing vector. It sits between the board buttons/LEDs and the gate bank.

---
 rtl/logic_lab_sequencer.sv | 167 ++++++++++++++++
 tb/tb_logic_lab_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_lab_sequencer.sv
// Drives the 3-bit input bus of the registered gate bank: debounced buttons in manual mode,
// or an eight-vector self-test against a golden model in auto mode.
module logic_lab_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STEP_CYCLES     = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [2:0] btn_raw,
   input  logic       mode_auto,
   input  logic       start,
   input  logic [6:0] core_out,
   output logic [2:0] core_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] fail_vector,
   output logic [6:0] fail_mask,
   output logic [2:0] state_dbg
);

   localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [DCW-1:0] DMAX = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SCW-1:0] SMAX = SCW'(STEP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_APPLY = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state, state_d;

   logic [2:0]     sync1, sync2, db;
   logic [DCW-1:0] dcnt [3];

   logic [2:0]     vec, vec_d;
   logic [SCW-1:0] wcnt, wcnt_d;
   logic [2:0]     core_in_d, fail_vector_d;
   logic [6:0]     fail_mask_d, diff;
   logic           pass_d;

   function automatic logic [6:0] golden(input logic [2:0] v);
      logic [6:0] g;
      g[0] = v[0] & v[1];
      g[1] = ~(v[0] & v[1]);
      g[2] = v[0] | v[1] | v[2];
      g[3] = ~(v[0] | v[1]);
      g[4] = v[0] ^ v[1] ^ v[2];
      g[5] = v[2] ? v[1] : v[0];
      g[6] = v[0] ^ v[1];
      return g;
   endfunction

   // Per-button debounce: the counter only runs while synchronized and debounced values disagree.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int i = 0; i < 3; i++) dcnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == db[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DMAX) begin
               db[i]   <= sync2[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_d;
   end

   assign diff = golden(vec) ^ core_out;

   always_comb begin
      state_d       = state;
      vec_d         = vec;
      wcnt_d        = wcnt;
      core_in_d     = core_in;
      pass_d        = pass;
      fail_vector_d = fail_vector;
      fail_mask_d   = fail_mask;
      case (state)
         S_IDLE, S_DONE: begin
            if (state == S_IDLE) core_in_d = db;
            if (mode_auto && start) begin
               state_d       = S_APPLY;
               vec_d         = '0;
               pass_d        = 1'b1;
               fail_vector_d = '0;
               fail_mask_d   = '0;
               core_in_d     = '0;
            end else if (!mode_auto) begin
               state_d = S_IDLE;
            end
         end
         S_APPLY: begin
            state_d = S_WAIT;
            wcnt_d  = '0;
         end
         S_WAIT: begin
            if (wcnt == SMAX) state_d = S_CHECK;
            else              wcnt_d  = wcnt + 1'b1;
         end
         S_CHECK: begin
            if (diff != '0 && pass) begin
               pass_d        = 1'b0;
               fail_vector_d = vec;
               fail_mask_d   = diff;
            end
            if (vec == 3'd7) begin
               state_d = S_DONE;
            end else begin
               vec_d     = vec + 3'd1;
               core_in_d = vec + 3'd1;
               state_d   = S_APPLY;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort overrides any run-state decision; core_in reverts once IDLE is reached.
      if (!mode_auto && (state == S_APPLY || state == S_WAIT || state == S_CHECK)) begin
         state_d       = S_IDLE;
         pass_d        = 1'b0;
         vec_d         = vec;
         core_in_d     = core_in;
         fail_vector_d = fail_vector;
         fail_mask_d   = fail_mask;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vec         <= '0;
         wcnt        <= '0;
         core_in     <= '0;
         pass        <= 1'b0;
         fail_vector <= '0;
         fail_mask   <= '0;
      end else begin
         vec         <= vec_d;
         wcnt        <= wcnt_d;
         core_in     <= core_in_d;
         pass        <= pass_d;
         fail_vector <= fail_vector_d;
         fail_mask   <= fail_mask_d;
      end
   end

   assign busy      = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_logic_lab_sequencer.sv
// Directed bench for logic_lab_sequencer: manual debounce, good and faulty self-test runs,
// restart from DONE, abort, and asynchronous reset mid-run.
module tb_logic_lab_sequencer;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [2:0] btn_raw;
   logic       mode_auto;
   logic       start;
   logic [6:0] core_out;
   logic [2:0] core_in;
   logic       busy, done, pass;
   logic [2:0] fail_vector;
   logic [6:0] fail_mask;
   logic [2:0] state_dbg;

   logic       mux_stuck0;
   int         n_vec = 0;
   int         n_err = 0;
   int         edge_n = 0;

   logic [6:0] exp_q[$];

   always #5 clock = ~clock;

   logic_lab_sequencer #(.DEBOUNCE_CYCLES(16), .STEP_CYCLES(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .btn_raw    (btn_raw),
      .mode_auto  (mode_auto),
      .start      (start),
      .core_out   (core_out),
      .core_in    (core_in),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail_vector(fail_vector),
      .fail_mask  (fail_mask),
      .state_dbg  (state_dbg)
   );

   // Gate bank truth table, bits [6:0] = XOR, MUX, sum, NOR, OR3, NAND, AND.
   function automatic logic [6:0] bank_tt(input logic [2:0] v);
      case (v)
         3'd0:    return 7'b0001010;
         3'd1:    return 7'b1110110;
         3'd2:    return 7'b1010110;
         3'd3:    return 7'b0100101;
         3'd4:    return 7'b0011110;
         3'd5:    return 7'b1000110;
         3'd6:    return 7'b1100110;
         default: return 7'b0110101;
      endcase
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) core_out <= '0;
      else          core_out <= bank_tt(core_in) & (mux_stuck0 ? 7'b1011111 : 7'b1111111);
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         edge_n++;
      end
   endtask

   task automatic tick_to(input int target);
      while (edge_n < target) tick(1);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_run();
      mode_auto = 1'b1;
      start     = 1'b1;
      tick(1);
      edge_n = 0;
      start  = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      btn_raw    = 3'b000;
      mode_auto  = 1'b0;
      start      = 1'b0;
      mux_stuck0 = 1'b0;

      // Reset state
      tick(3);
      chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("rst_core_in", 32'(core_in), 0);
      chk("rst_flags", {29'd0, busy, done, pass}, 0);
      chk("rst_fail", {22'd0, fail_vector, fail_mask}, 0);
      reset_n = 1'b1;
      tick(2);

      // Manual: 101 reaches core_in at edge 2+16+1
      btn_raw = 3'b101;
      edge_n  = 0;
      tick_to(18);
      chk("man_lat_before", 32'(core_in), 32'(3'b000));
      tick_to(19);
      chk("man_lat_at", 32'(core_in), 32'(3'b101));
      tick_to(24);
      btn_raw = 3'b111;
      tick(3);
      btn_raw = 3'b101;
      tick(10);
      chk("glitch_mid", 32'(core_in), 32'(3'b101));
      tick(15);
      chk("glitch_end", 32'(core_in), 32'(3'b101));

      // Good auto run, with stray start pulses while busy
      start_run();
      for (int v = 0; v < 8; v++) begin
         tick_to(6 * v + 1);
         chk($sformatf("good_core_in_v%0d", v), 32'(core_in), v);
         chk($sformatf("good_busy_v%0d", v), 32'(busy), 1);
         start = (v == 1 || v == 4);
      end
      start = 1'b0;
      tick_to(47);
      chk("good_done_47", 32'(done), 0);
      tick_to(48);
      exp_q.push_back(7'b0000000);
      chk("good_done_48", 32'(done), 1);
      chk("good_busy_48", 32'(busy), 0);
      chk("good_pass", 32'(pass), 1);
      chk("good_fail_vector", 32'(fail_vector), 0);
      chk("good_fail_mask", 32'(fail_mask), 32'(exp_q.pop_front()));
      chk("good_core_in_done", 32'(core_in), 7);

      // DONE -> IDLE when auto mode drops
      mode_auto = 1'b0;
      tick(1);
      chk("done_to_idle", 32'(state_dbg), 32'(ST_IDLE));
      chk("done_to_idle_done", 32'(done), 0);

      // MUX stuck at 0: golden MUX picks b0 when b2=0, so vector 001 fails first
      mux_stuck0 = 1'b1;
      start_run();
      start = 1'b1;
      tick_to(13);
      chk("mux_first_pass", 32'(pass), 0);
      chk("mux_first_vec", 32'(fail_vector), 32'(3'b001));
      tick_to(48);
      exp_q.push_back(7'b0100000);
      chk("mux_done", 32'(done), 1);
      chk("mux_pass", 32'(pass), 0);
      chk("mux_fail_vector", 32'(fail_vector), 32'(3'b001));
      chk("mux_fail_mask", 32'(fail_mask), 32'(exp_q.pop_front()));
      // start still high: restart straight from DONE
      tick_to(49);
      chk("restart_busy", 32'(busy), 1);
      chk("restart_done", 32'(done), 0);
      chk("restart_pass", 32'(pass), 1);
      chk("restart_fail", {22'd0, fail_vector, fail_mask}, 0);
      chk("restart_core_in", 32'(core_in), 0);
      start      = 1'b0;
      mux_stuck0 = 1'b0;
      tick_to(96);
      chk("restart_done_96", 32'(done), 0);
      tick_to(97);
      chk("restart_done_97", 32'(done), 1);
      chk("restart_pass_end", 32'(pass), 1);

      // Abort in WAIT of vector 4
      mode_auto = 1'b0;
      tick(2);
      chk("pre_abort_core_in", 32'(core_in), 32'(3'b101));
      start_run();
      tick_to(26);
      chk("abort_pre_state", 32'(state_dbg), 32'(ST_WAIT));
      chk("abort_pre_core_in", 32'(core_in), 4);
      mode_auto = 1'b0;
      tick(1);
      chk("abort_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("abort_busy", 32'(busy), 0);
      chk("abort_pass", 32'(pass), 0);
      chk("abort_core_in_hold", 32'(core_in), 4);
      tick(1);
      chk("abort_core_in_btn", 32'(core_in), 32'(3'b101));
      tick(10);
      chk("abort_no_done", 32'(done), 0);

      // Asynchronous reset in CHECK of vector 3
      start_run();
      tick_to(23);
      chk("arst_pre_state", 32'(state_dbg), 32'(ST_CHECK));
      chk("arst_pre_core_in", 32'(core_in), 3);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("arst_core_in", 32'(core_in), 0);
      chk("arst_flags", {29'd0, busy, done, pass}, 0);
      chk("arst_fail", {22'd0, fail_vector, fail_mask}, 0);
      reset_n = 1'b1;
      tick(1);
      chk("arst_release_state", 32'(state_dbg), 32'(ST_IDLE));
      chk("arst_release_flags", {29'd0, busy, done, pass}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
